fifo_rd_ctrl: RTL and testbench

//   Read-side drain controller for the asynchronous FIFO. Lives entirely in the read clock domain.

---
 rtl/fifo_rd_ctrl_if.sv | 23 ++
 rtl/fifo_rd_ctrl.sv | 94 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Downstream valid/ready stream carrying FIFO words drained by fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side drain controller: pops an async FIFO at most every other cycle into a
// 2-entry buffer and presents it as a valid/ready stream with burst framing.
module fifo_rd_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic             rd_clk,
    input  logic             rd_rstn,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             fifo_rd_en,
    fifo_rd_ctrl_if.master   strm,
    output logic [15:0]      rd_count
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        START0 = 2'd0,
        START1 = 2'd1,
        IDLE   = 2'd2,
        CAPT   = 2'd3
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  buf_mem [2];
    logic              head;
    logic              tail;
    logic [1:0]        buf_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              capt;
    logic              xfer;

    // A read is only issued with room for its word, one cycle after the previous capture
    assign fifo_rd_en = (state == IDLE) && !fifo_empty && (buf_cnt <= 2'd1);
    assign capt       = (state == CAPT);
    assign xfer       = strm.m_valid && strm.m_ready;

    assign strm.m_valid = (buf_cnt != 2'd0);
    assign strm.m_data  = buf_mem[head];
    assign strm.m_last  = strm.m_valid && (beat_cnt == BEAT_MAX);

    // Sequencer: two blind cycles after reset while the FIFO empty flag settles
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state <= START0;
        end else begin
            case (state)
                START0:  state <= START1;
                START1:  state <= IDLE;
                IDLE:    state <= fifo_rd_en ? CAPT : IDLE;
                CAPT:    state <= IDLE;
                default: state <= START0;
            endcase
        end
    end

    // Output buffer; capture and transfer may coincide, leaving the count unchanged
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (capt) begin
                buf_mem[tail] <= fifo_rd_data;
                tail          <= ~tail;
            end
            if (xfer) begin
                head <= ~head;
            end
            if (capt && !xfer) begin
                buf_cnt <= buf_cnt + 2'd1;
            end else if (!capt && xfer) begin
                buf_cnt <= buf_cnt - 2'd1;
            end
        end
    end

    // Burst position and running transfer count
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            beat_cnt <= '0;
            rd_count <= 16'd0;
        end else if (xfer) begin
            beat_cnt <= (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + BEAT_W'(1);
            rd_count <= rd_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a queue-based FIFO model feeds the DUT and a
// negedge monitor checks every downstream word against the push order.
module tb_fifo_rd_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BL    = 4;

    logic             rd_clk = 1'b0;
    logic             rd_rstn = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_rd_data = '0;
    logic             fifo_rd_en;
    logic [15:0]      rd_count;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH)) s_if ();

    fifo_rd_ctrl #(.WIDTH(WIDTH), .BURST_LEN(BL)) dut (
        .rd_clk       (rd_clk),
        .rd_rstn      (rd_rstn),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .strm         (s_if.master),
        .rd_count     (rd_count)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;
    int n_pops = 0;
    logic [WIDTH-1:0] fifo_q [$];
    logic [WIDTH-1:0] exp_q  [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO model: registered empty flag, read data one cycle after the strobe
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL underrun: rd_en with %0d words stored, expected >0", fifo_q.size());
            end else begin
                fifo_rd_data <= fifo_q.pop_front();
                n_pops++;
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: ordering, burst framing, count, stall stability, read spacing
    logic             prev_stall = 1'b0;
    logic             prev_en    = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    logic             prev_last  = 1'b0;

    always @(negedge rd_clk) begin
        if (!rd_rstn) begin
            prev_stall = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (fifo_rd_en) chk("rd_en_spacing", 32'(prev_en), 32'd0);
            prev_en = fifo_rd_en;
            if (prev_stall) begin
                chk("stall_valid", 32'(s_if.m_valid), 32'd1);
                chk("stall_data", 32'(s_if.m_data), 32'(prev_data));
                chk("stall_last", 32'(s_if.m_last), 32'(prev_last));
            end
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_last  = s_if.m_last;
            if (s_if.m_valid && s_if.m_ready) begin
                chk("rd_count", 32'(rd_count), 32'(16'(n_xfer)));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", s_if.m_data);
                end else begin
                    chk("data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
                    chk("last", 32'(s_if.m_last), 32'((n_xfer % int'(BL)) == int'(BL) - 1));
                end
                n_xfer++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        rd_rstn = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        n_xfer = 0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || s_if.m_valid) && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 300) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d words pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rd_en"},    32'(fifo_rd_en), 32'd0);
        chk({name, "_m_valid"},  32'(s_if.m_valid), 32'd0);
        chk({name, "_m_data"},   32'(s_if.m_data), 32'd0);
        chk({name, "_m_last"},   32'(s_if.m_last), 32'd0);
        chk({name, "_rd_count"}, 32'(rd_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int k;
        int n0;
        s_if.m_ready = 1'b0;
        do_reset();

        // Reset held with a non-empty FIFO, then the two blind cycles
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk("rst_hold_rd_en", 32'(fifo_rd_en), 32'd0);
            tick();
        end
        chk_reset_outputs("rst");
        rd_rstn = 1'b1;
        chk("start0_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        chk("start1_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        chk("first_rd_en", 32'(fifo_rd_en), 32'd1);

        // Streaming 01..08 with ready held high
        s_if.m_ready = 1'b1;
        drain("stream");
        chk("stream_count", 32'(rd_count), 32'd8);

        // Backpressure: only two reads fit, head held
        s_if.m_ready = 1'b0;
        p0 = n_pops;
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        tick(20);
        chk("bp_reads", 32'(n_pops - p0), 32'd2);
        chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("bp_head", 32'(s_if.m_data), 32'h01);
        s_if.m_ready = 1'b1;
        drain("backpressure");
        chk("bp_count", 32'(rd_count), 32'd13);

        // Single word then empty
        p0 = n_pops;
        push_word(8'hA5);
        drain("empty_edge");
        tick(4);
        chk("single_read", 32'(n_pops - p0), 32'd1);
        chk("empty_valid", 32'(s_if.m_valid), 32'd0);

        // Capture coinciding with a transfer
        s_if.m_ready = 1'b0;
        p0 = n_pops;
        push_word(8'hB1);
        push_word(8'hB2);
        k = 0;
        while (n_pops - p0 < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("simul_second_read", 32'(n_pops - p0), 32'd2);
        chk("simul_head_before", 32'(s_if.m_data), 32'hB1);
        s_if.m_ready = 1'b1;
        tick();
        chk("simul_head_after", 32'(s_if.m_data), 32'hB2);
        chk("simul_valid", 32'(s_if.m_valid), 32'd1);
        drain("simultaneous");

        // Randomized traffic and backpressure
        for (int i = 0; i < 500; i++) begin
            s_if.m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8) push_word(8'($urandom));
            tick();
        end
        s_if.m_ready = 1'b1;
        drain("random");

        // Reset two beats into a burst
        n0 = n_xfer;
        for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
        k = 0;
        while (!(n_xfer > n0 && (n_xfer % int'(BL)) == 2) && k < 100) begin
            tick();
            k++;
        end
        chk("midburst_reached", 32'(n_xfer % int'(BL)), 32'd2);
        do_reset();
        #1;
        chk_reset_outputs("midrst");
        tick();
        chk_reset_outputs("midrst_hold");
        rd_rstn = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'(8'h20 + i));
        drain("post_reset");
        chk("post_reset_count", 32'(rd_count), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
